// File: rtl/dem_pkg.sv
// Shared types, constants and the signed clip helper for the DEM loop-filter slice.
package dem_pkg;

    localparam int ACC_W_DEF = 12;
    localparam int LFV_W_DEF = 8;

    typedef enum int {
        ORDER_FIRST  = 1,
        ORDER_SECOND = 2
    } order_e;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;
    typedef logic signed [LFV_W_DEF-1:0] lfv_t;

    // Clip a signed value into the two's-complement range of a 'width'-bit word (width <= 31).
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                       input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/dem_sat_accum.sv
// Signed saturating accumulator; exposes the post-add value combinationally so a
// following stage (or the output clip) can use it in the same sample.
module dem_sat_accum #(
    parameter int W = 12
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic signed [W-1:0] add_i,
    output logic signed [W-1:0] nxt_o,
    output logic                sat_o
);

    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] r_acc;
    logic        [W:0]   w_sum;

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    assign w_sum = {add_i[W-1], add_i} + {r_acc[W-1], r_acc};
    assign sat_o = w_sum[W] ^ w_sum[W-1];

    // NOTE: every branch assigns nxt_o, so this stays purely combinational (no latch).
    always_comb begin
        nxt_o = w_sum[W-1:0];
        if (sat_o)
            nxt_o = w_sum[W] ? ACC_MIN : ACC_MAX;
    end

    // NOTE: state registers use non-blocking assignment; clear wins over enable.
    always_ff @(posedge clk_i) begin
        if (clr_i)
            r_acc <= '0;
        else if (en_i)
            r_acc <= nxt_o;
    end

endmodule

// File: rtl/dem_loop_filter.sv
// Mismatch-shaping loop filter for one DEM switching-block node, with a node
// conservation checker (x_out1 + x_out2 must equal x_in) and saturating error count.
module dem_loop_filter
    import dem_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ORDER     = ORDER_SECOND,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     s_in_i,
    input  logic [WIDTH-1:0]     x_in_i,
    input  logic [WIDTH-1:0]     x_out1_i,
    input  logic [WIDTH-1:0]     x_out2_i,
    output logic [WIDTH-1:0]     loop_filter_value_o,
    output logic                 valid_o,
    output logic                 sat_o,
    output logic                 mismatch_err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    logic signed [ACC_W-1:0]     w_s_ext;
    logic signed [ACC_W-1:0]     w_stage_in  [ORDER];
    logic signed [ACC_W-1:0]     w_stage_nxt [ORDER];
    logic        [ORDER-1:0]     w_stage_sat;
    logic signed [ACC_W-1:0]     w_y;
    logic signed [31:0]          w_y_ext;
    logic signed [31:0]          w_clipped;
    logic        [WIDTH-1:0]     w_lfv_next;
    logic                        w_out_clip;
    logic        [WIDTH:0]       w_branch_sum;
    logic                        w_mismatch;

    logic        [WIDTH-1:0]     r_lfv;
    logic                        r_valid;
    logic                        r_sat;
    logic                        r_mismatch;
    logic        [ERR_CNT_W-1:0] r_err_count;

    assign w_s_ext = {{(ACC_W-WIDTH){s_in_i[WIDTH-1]}}, s_in_i};

    // Stage 0 integrates s; each later stage integrates the previous stage's new value.
    for (genvar k = 0; k < ORDER; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_stage_in[k] = w_s_ext;
        end else begin : g_chain
            assign w_stage_in[k] = w_stage_nxt[k-1];
        end

        dem_sat_accum #(.W(ACC_W)) u_acc (
            .clk_i (clk_i),
            .en_i  (valid_i),
            .clr_i (reset_i),
            .add_i (w_stage_in[k]),
            .nxt_o (w_stage_nxt[k]),
            .sat_o (w_stage_sat[k])
        );
    end

    assign w_y        = w_stage_nxt[ORDER-1];
    assign w_y_ext    = {{(32-ACC_W){w_y[ACC_W-1]}}, w_y};
    assign w_clipped  = sat_signed(w_y_ext, WIDTH);
    assign w_lfv_next = w_clipped[WIDTH-1:0];
    assign w_out_clip = (w_clipped != w_y_ext);

    // Sum is one bit wider than the codes, so a carry out is a real mismatch.
    assign w_branch_sum = {1'b0, x_out1_i} + {1'b0, x_out2_i};
    assign w_mismatch   = (w_branch_sum != {1'b0, x_in_i});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfv       <= '0;
            r_valid     <= 1'b0;
            r_sat       <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_valid    <= valid_i;
            r_sat      <= valid_i & ((|w_stage_sat) | w_out_clip);
            r_mismatch <= valid_i & w_mismatch;
            if (valid_i) begin
                r_lfv <= w_lfv_next;
                if (w_mismatch && (r_err_count != '1))
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign loop_filter_value_o = r_lfv;
    assign valid_o             = r_valid;
    assign sat_o               = r_sat;
    assign mismatch_err_o      = r_mismatch;
    assign err_count_o         = r_err_count;

endmodule
